// File: rtl/game_pkg.sv
// Shared definitions for the guessing-game blocks (digit entry, scoring,
// display control).
//   KEY_*   : decoded key codes from the keypad/keyboard front end
//   DIGITS  : digits per entry
//   state_t : digit-entry controller states
package game_pkg;

    localparam int DIGITS = 3;

    localparam logic [3:0] KEY_ENTER = 4'd10;
    localparam logic [3:0] KEY_BKSP  = 4'd11;
    localparam logic [3:0] KEY_CLR   = 4'd12;

    typedef enum logic [1:0] {
        ENTRY = 2'd0,
        FULL  = 2'd1,
        HOLD  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/digit_dup_check.sv
// Combinational duplicate check. Reports whether a candidate digit equals
// any of the first 'count' slots. Slots beyond count are ignored. Also used
// downstream for A/B scoring.
//   cand        : candidate digit
//   slot1..3    : held digits, leftmost first
//   count       : number of valid slots, 0-3
//   match       : candidate equals a valid slot
module digit_dup_check (
    input  logic [3:0] cand,
    input  logic [3:0] slot1,
    input  logic [3:0] slot2,
    input  logic [3:0] slot3,
    input  logic [1:0] count,
    output logic       match
);
    always_comb begin
        match = ((count > 2'd0) && (slot1 == cand)) ||
                ((count > 2'd1) && (slot2 == cand)) ||
                ((count > 2'd2) && (slot3 == cand));
    end
endmodule

// File: rtl/guess_entry.sv
// Digit-entry stage: assembles a 3-digit entry with distinct digits from
// decoded key events and strobes oNumRdy on ENTER once the entry is full.
// After a submit, keys are dropped for HOLDOFF cycles. The entry then stays
// visible until the next digit or CLEAR starts a new one.
//   CLK, reset       : clock, synchronous active-high reset
//   key_valid        : key_code valid this cycle
//   key_code         : 0-9 digit, 10 ENTER, 11 BACKSPACE, 12 CLEAR
//   en               : entry enable, keys dropped while low
//   oNum1..oNum3     : held digits or EMPTY_CODE
//   oCount           : number of digits held
//   oNumRdy          : one-cycle pulse, complete entry submitted
//   oErr             : one-cycle pulse, key rejected
module guess_entry
    import game_pkg::*;
#(
    parameter logic [3:0] EMPTY_CODE = 4'hF,
    parameter int         HOLDOFF    = 2
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    input  logic       en,
    output logic [3:0] oNum1,
    output logic [3:0] oNum2,
    output logic [3:0] oNum3,
    output logic [1:0] oCount,
    output logic       oNumRdy,
    output logic       oErr
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

    state_t                   state;
    logic [HW-1:0]            hold_cnt;
    logic [DIGITS-1:0][3:0]   slots;
    logic                     key;
    logic                     is_digit;
    logic                     dup;

    assign key      = key_valid && en;
    assign is_digit = key_code <= 4'd9;

    assign oNum1 = slots[0];
    assign oNum2 = slots[1];
    assign oNum3 = slots[2];

    digit_dup_check u_dup (
        .cand  (key_code),
        .slot1 (slots[0]),
        .slot2 (slots[1]),
        .slot3 (slots[2]),
        .count (oCount),
        .match (dup)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= ENTRY;
            hold_cnt <= '0;
            slots    <= {DIGITS{EMPTY_CODE}};
            oCount   <= 2'd0;
            oNumRdy  <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            oNumRdy <= 1'b0;
            oErr    <= 1'b0;
            case (state)
                ENTRY: begin
                    if (key) begin
                        if (is_digit) begin
                            if (dup) begin
                                oErr <= 1'b1;
                            end else begin
                                slots[oCount] <= key_code;
                                oCount        <= oCount + 2'd1;
                                if (oCount == 2'd2)
                                    state <= FULL;
                            end
                        end else if (key_code == KEY_BKSP) begin
                            if (oCount == 2'd0) begin
                                oErr <= 1'b1;
                            end else begin
                                slots[oCount - 2'd1] <= EMPTY_CODE;
                                oCount               <= oCount - 2'd1;
                            end
                        end else if (key_code == KEY_CLR) begin
                            slots  <= {DIGITS{EMPTY_CODE}};
                            oCount <= 2'd0;
                        end else if (key_code == KEY_ENTER) begin
                            oErr <= 1'b1;
                        end
                    end
                end

                FULL: begin
                    if (key) begin
                        if (is_digit) begin
                            oErr <= 1'b1;
                        end else if (key_code == KEY_BKSP) begin
                            slots[2] <= EMPTY_CODE;
                            oCount   <= 2'd2;
                            state    <= ENTRY;
                        end else if (key_code == KEY_CLR) begin
                            slots  <= {DIGITS{EMPTY_CODE}};
                            oCount <= 2'd0;
                            state  <= ENTRY;
                        end else if (key_code == KEY_ENTER) begin
                            oNumRdy  <= 1'b1;
                            hold_cnt <= '0;
                            state    <= HOLD;
                        end
                    end
                end

                // Keys dropped for HOLDOFF cycles regardless of en.
                HOLD: begin
                    if (hold_cnt == HW'(HOLDOFF - 1))
                        state <= DONE;
                    else
                        hold_cnt <= hold_cnt + 1'b1;
                end

                // Submitted entry stays visible; a digit starts a fresh entry
                // in the same update, so no duplicate check is needed here.
                DONE: begin
                    if (key) begin
                        if (is_digit) begin
                            slots  <= {EMPTY_CODE, EMPTY_CODE, key_code};
                            oCount <= 2'd1;
                            state  <= ENTRY;
                        end else if (key_code == KEY_CLR) begin
                            slots  <= {DIGITS{EMPTY_CODE}};
                            oCount <= 2'd0;
                            state  <= ENTRY;
                        end else if (key_code == KEY_BKSP ||
                                     key_code == KEY_ENTER) begin
                            oErr <= 1'b1;
                        end
                    end
                end

                default: state <= ENTRY;
            endcase
        end
    end
endmodule
